// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM states, word width and index-width helper for the UART transmit arbiter
package uart_arb_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_ACK, S_DRAIN} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational requester picker, round-robin from ptr+1 or fixed lowest-index when UART_ARB_FIXED_PRIO_EN
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  localparam int IW = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
`ifndef UART_ARB_FIXED_PRIO_EN
  input  logic [IW-1:0]    ptr,
`endif
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             any
);
  logic [IW-1:0] j;
  // Scan from the lowest priority upward so the highest-priority valid index is written last.
  always_comb begin
    idx = '0;
    j = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = IW'(i);
      if (valid[j]) idx = j;
    end
`else
    for (int k = N_REQ; k >= 1; k--) begin
      j = IW'((int'(ptr) + k) % N_REQ);
      if (valid[j]) idx = j;
    end
`endif
  end
  assign any = |valid;
  assign grant = any ? N_REQ'(1) << idx : '0;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one 32-bit-word UART transmitter between N_REQ requesters.
// Define UART_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ACK_LIMIT = 4,
  localparam int IW = idx_w(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*WORD_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [WORD_W-1:0]       tx_sdata,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic [IW-1:0]           grant_id,
  output logic                    arb_busy,
  output logic                    ack_err
);
  localparam int CW = idx_w(ACK_LIMIT);
  state_t state, state_nx;
  logic [CW-1:0] ack_cnt;
  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0] pick_idx;
  logic pick_any, hs, ack_to;
  logic [WORD_W-1:0] pick_word;
`ifndef UART_ARB_FIXED_PRIO_EN
  logic [IW-1:0] rr_ptr;
`endif

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .valid(req_valid),
`ifndef UART_ARB_FIXED_PRIO_EN
    .ptr(rr_ptr),
`endif
    .grant(pick_oh),
    .idx(pick_idx),
    .any(pick_any)
  );

  always_comb begin
    pick_word = '0;
    for (int i = 0; i < N_REQ; i++)
      pick_word |= pick_oh[i] ? req_data[i*WORD_W +: WORD_W] : '0;
  end

  // A word is accepted only while idle and the transmitter has finished any earlier frame.
  assign hs = state == S_IDLE && !tx_busy && pick_any;
  assign ack_to = !tx_busy && ack_cnt == CW'(ACK_LIMIT - 1);

  always_ff @(posedge clk)
    state <= !rstn ? S_IDLE : state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = hs ? S_LAUNCH : S_IDLE;
      S_LAUNCH: state_nx = S_ACK;
      S_ACK:    state_nx = tx_busy ? S_DRAIN : ack_to ? S_IDLE : S_ACK;
      default:  state_nx = tx_busy ? S_DRAIN : S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (rstn && hs) ? pick_oh : '0;
    tx_start = state == S_LAUNCH;
    arb_busy = state != S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_sdata <= '0;
      grant_id <= '0;
      ack_err <= 1'b0;
      ack_cnt <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
      rr_ptr <= IW'(N_REQ - 1);
`endif
    end else begin
      if (hs) begin
        tx_sdata <= pick_word;
        grant_id <= pick_idx;
`ifndef UART_ARB_FIXED_PRIO_EN
        rr_ptr <= pick_idx;
`endif
      end
      ack_cnt <= state == S_ACK ? ack_cnt + CW'(1) : '0;
      if (state == S_ACK && ack_to) ack_err <= 1'b1;
    end
  end
endmodule
